// File: rtl/reg_file_ctrl.sv
// Sequencer/arbiter for the core register file: zero-fills all registers after
// reset, then shares the write port and srcB select between core writeback and debug.
module reg_file_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int WORDS       = 32,
  parameter int SELECT_SIZE = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   core_we_ni,
  input  logic [SELECT_SIZE-1:0] core_dst_i,
  input  logic [DATA_WIDTH-1:0]  core_data_i,
  input  logic [SELECT_SIZE-1:0] core_srcB_i,
  output logic                   stall_o,
  output logic                   ready_o,
  input  logic                   dbg_req_i,
  input  logic                   dbg_wr_i,
  input  logic [SELECT_SIZE-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0]  dbg_wdata_i,
  output logic                   dbg_ack_o,
  output logic [DATA_WIDTH-1:0]  dbg_rdata_o,
  output logic                   rf_we_no,
  output logic [SELECT_SIZE-1:0] rf_dst_o,
  output logic [DATA_WIDTH-1:0]  rf_data_o,
  output logic [SELECT_SIZE-1:0] rf_srcB_o,
  input  logic [DATA_WIDTH-1:0]  rf_srcB_data_i
);

  // Debug handshake: dbg_req_i is a level request; dbg_ack_o rises two cycles
  // after acceptance and stays high until dbg_req_i is seen low, then drops.

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_DBG_WR,
    ST_DBG_RD,
    ST_DBG_ACK
  } state_e;

  localparam logic [SELECT_SIZE-1:0] LAST_REG = SELECT_SIZE'(WORDS - 1);

  state_e                 state_q, state_d;
  logic [SELECT_SIZE-1:0] clr_cnt_q, clr_cnt_d;
  logic [SELECT_SIZE-1:0] dbg_addr_q, dbg_addr_d;
  logic [DATA_WIDTH-1:0]  dbg_wdata_q, dbg_wdata_d;
  logic [DATA_WIDTH-1:0]  dbg_rdata_q, dbg_rdata_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_wdata_q <= dbg_wdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_wdata_d = dbg_wdata_q;
    dbg_rdata_d = dbg_rdata_q;
    stall_o     = 1'b1;
    ready_o     = 1'b1;
    dbg_ack_o   = 1'b0;
    rf_we_no    = 1'b1;
    rf_dst_o    = '0;
    rf_data_o   = '0;
    rf_srcB_o   = core_srcB_i;

    case (state_q)
      ST_CLEAR: begin
        ready_o   = 1'b0;
        rf_we_no  = 1'b0;
        rf_dst_o  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + SELECT_SIZE'(1);
        if (clr_cnt_q == LAST_REG) begin
          clr_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        stall_o   = 1'b0;
        rf_we_no  = core_we_ni | (core_dst_i == '0);
        rf_dst_o  = core_dst_i;
        rf_data_o = core_data_i;
        // A core writeback in the same cycle wins; debug is re-sampled next cycle.
        if (dbg_req_i && core_we_ni) begin
          dbg_addr_d  = dbg_addr_i;
          dbg_wdata_d = dbg_wdata_i;
          state_d     = dbg_wr_i ? ST_DBG_WR : ST_DBG_RD;
        end
      end
      ST_DBG_WR: begin
        rf_we_no  = (dbg_addr_q == '0);
        rf_dst_o  = dbg_addr_q;
        rf_data_o = dbg_wdata_q;
        state_d   = ST_DBG_ACK;
      end
      ST_DBG_RD: begin
        rf_srcB_o   = dbg_addr_q;
        dbg_rdata_d = rf_srcB_data_i;
        state_d     = ST_DBG_ACK;
      end
      ST_DBG_ACK: begin
        dbg_ack_o = 1'b1;
        if (!dbg_req_i) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase

    // While reset is held the file keeps receiving x0 <= 0 regardless of state.
    if (reset_i) begin
      stall_o   = 1'b1;
      ready_o   = 1'b0;
      dbg_ack_o = 1'b0;
      rf_we_no  = 1'b0;
      rf_dst_o  = '0;
      rf_data_o = '0;
    end
  end

  assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: a behavioural register file driven by the DUT plus a
// reference array of expected register contents updated from the block's rules.
module tb_reg_file_ctrl;
  localparam int DW = 32;
  localparam int NW = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          core_we_ni;
  logic [SW-1:0] core_dst_i;
  logic [DW-1:0] core_data_i;
  logic [SW-1:0] core_srcB_i;
  logic          stall_o;
  logic          ready_o;
  logic          dbg_req_i;
  logic          dbg_wr_i;
  logic [SW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;
  logic          dbg_ack_o;
  logic [DW-1:0] dbg_rdata_o;
  logic          rf_we_no;
  logic [SW-1:0] rf_dst_o;
  logic [DW-1:0] rf_data_o;
  logic [SW-1:0] rf_srcB_o;
  logic [DW-1:0] rf_srcB_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] rf_mem [NW];
  int            wr_cnt  = 0;
  logic          preload = 1'b0;
  logic [DW-1:0] ref_regs [NW];
  logic [DW-1:0] exp_rdata;
  logic [DW-1:0] exp_q [$];

  reg_file_ctrl #(.DATA_WIDTH(DW), .WORDS(NW), .SELECT_SIZE(SW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .core_we_ni(core_we_ni), .core_dst_i(core_dst_i), .core_data_i(core_data_i),
    .core_srcB_i(core_srcB_i), .stall_o(stall_o), .ready_o(ready_o),
    .dbg_req_i(dbg_req_i), .dbg_wr_i(dbg_wr_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
    .rf_we_no(rf_we_no), .rf_dst_o(rf_dst_o), .rf_data_o(rf_data_o),
    .rf_srcB_o(rf_srcB_o), .rf_srcB_data_i(rf_srcB_data_i)
  );

  // Clock and the external register file
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NW; i++) rf_mem[i] <= '1;
    end else if (!rf_we_no) begin
      rf_mem[rf_dst_o] <= rf_data_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  assign rf_srcB_data_i = rf_mem[rf_srcB_o];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    core_we_ni  = 1'b1;
    core_dst_i  = '0;
    core_data_i = '0;
    core_srcB_i = '0;
    dbg_req_i   = 1'b0;
    dbg_wr_i    = 1'b0;
    dbg_addr_i  = '0;
    dbg_wdata_i = '0;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NW; i++)
      check($sformatf("%s_x%0d", tag, i), rf_mem[i], ref_regs[i]);
  endtask

  // Called with reset just released; expects x0..x31 in order, then ready.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      if (n < NW) begin
        check($sformatf("%s_dst%0d", tag, n), 32'(rf_dst_o), 32'(n));
        check($sformatf("%s_we%0d", tag, n), 32'(rf_we_no), 32'(0));
        check($sformatf("%s_data%0d", tag, n), rf_data_o, 32'(0));
      end
      check($sformatf("%s_noack%0d", tag, n), 32'(dbg_ack_o), 32'(0));
      step();
      n++;
    end
    check({tag, "_cycles"}, 32'(n), 32'(NW));
    check({tag, "_stall"}, 32'(stall_o), 32'(0));
    for (int i = 0; i < NW; i++) ref_regs[i] = '0;
  endtask

  task automatic core_wr(input logic we_n, input logic [SW-1:0] dst,
                         input logic [DW-1:0] data, input logic [SW-1:0] srcb);
    logic exp_we_n;
    core_we_ni  = we_n;
    core_dst_i  = dst;
    core_data_i = data;
    core_srcB_i = srcb;
    settle();
    exp_we_n = we_n | (dst == 0);
    check("core_we_n", 32'(rf_we_no), 32'(exp_we_n));
    if (!exp_we_n) begin
      check("core_dst", 32'(rf_dst_o), 32'(dst));
      check("core_data", rf_data_o, data);
      ref_regs[dst] = data;
    end
    check("core_srcb", 32'(rf_srcB_o), 32'(srcb));
    check("core_stall", 32'(stall_o), 32'(0));
    step();
    core_we_ni = 1'b1;
  endtask

  // Request is being sampled in the current IDLE cycle T.
  task automatic dbg_finish(input bit wr, input logic [SW-1:0] addr,
                            input logic [DW-1:0] wdata, input int hold);
    int wc;
    logic [SW-1:0] sb;
    if (!wr) exp_q.push_back(ref_regs[addr]);
    step();
    dbg_addr_i  = SW'($urandom);
    dbg_wdata_i = $urandom;
    sb          = SW'($urandom);
    core_srcB_i = sb;
    settle();
    check("t1_stall", 32'(stall_o), 32'(1));
    check("t1_ack", 32'(dbg_ack_o), 32'(0));
    if (wr) begin
      check("t1_we_n", 32'(rf_we_no), 32'(addr == 0));
      if (addr != 0) begin
        check("t1_dst", 32'(rf_dst_o), 32'(addr));
        check("t1_data", rf_data_o, wdata);
      end
    end else begin
      check("t1_we_n_rd", 32'(rf_we_no), 32'(1));
      check("t1_srcb", 32'(rf_srcB_o), 32'(addr));
    end
    step();
    check("t2_ack", 32'(dbg_ack_o), 32'(1));
    check("t2_stall", 32'(stall_o), 32'(1));
    check("t2_srcb", 32'(rf_srcB_o), 32'(sb));
    if (wr && addr != 0) ref_regs[addr] = wdata;
    if (!wr) exp_rdata = exp_q.pop_front();
    check("rdata", dbg_rdata_o, exp_rdata);
    wc = wr_cnt;
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_ack", 32'(dbg_ack_o), 32'(1));
      check("hold_stall", 32'(stall_o), 32'(1));
      check("hold_we_n", 32'(rf_we_no), 32'(1));
    end
    dbg_req_i = 1'b0;
    step();
    check("u1_ack", 32'(dbg_ack_o), 32'(0));
    check("u1_stall", 32'(stall_o), 32'(0));
    check("no_extra_write", 32'(wr_cnt), 32'(wc));
  endtask

  task automatic dbg_txn(input bit wr, input logic [SW-1:0] addr,
                         input logic [DW-1:0] wdata, input int hold);
    core_we_ni  = 1'b1;
    dbg_req_i   = 1'b1;
    dbg_wr_i    = wr;
    dbg_addr_i  = addr;
    dbg_wdata_i = wdata;
    dbg_finish(wr, addr, wdata, hold);
  endtask

  initial begin
    idle_inputs();
    reset_i   = 1'b0;
    exp_rdata = '0;
    preload   = 1'b1;
    step();
    preload = 1'b0;

    // Reset pulse and full clear
    reset_i = 1'b1;
    settle();
    check("rst_stall", 32'(stall_o), 32'(1));
    check("rst_ready", 32'(ready_o), 32'(0));
    check("rst_ack", 32'(dbg_ack_o), 32'(0));
    check("rst_we_n", 32'(rf_we_no), 32'(0));
    check("rst_dst", 32'(rf_dst_o), 32'(0));
    check("rst_data", rf_data_o, 32'(0));
    step();
    check("rst_rdata", dbg_rdata_o, 32'(0));
    reset_i = 1'b0;
    settle();
    wait_clear("clr");
    check_all_regs("after_clr");

    // Core writes, including the x0 guard
    core_wr(1'b0, 5'd0, 32'hDEADBEEF, 5'd3);
    for (int i = 0; i < 40; i++)
      core_wr(1'($urandom_range(0, 1)), SW'($urandom), $urandom, SW'($urandom));
    check_all_regs("core");

    // Directed debug write/read and x0 protection
    dbg_txn(1'b1, 5'd7, 32'h12345678, 0);
    dbg_txn(1'b0, 5'd7, 32'h0, 1);
    check("x7_readback", dbg_rdata_o, 32'h12345678);
    dbg_txn(1'b1, 5'd0, 32'hFFFF0000, 0);
    dbg_txn(1'b0, 5'd0, 32'h0, 0);
    check("x0_readback", dbg_rdata_o, 32'h0);

    // Collision: core write and debug request in the same IDLE cycle
    dbg_req_i   = 1'b1;
    dbg_wr_i    = 1'b1;
    dbg_addr_i  = 5'd5;
    dbg_wdata_i = 32'h5A5A5A5A;
    core_we_ni  = 1'b0;
    core_dst_i  = 5'd5;
    core_data_i = 32'hA5A5A5A5;
    settle();
    check("col_core_we_n", 32'(rf_we_no), 32'(0));
    check("col_core_data", rf_data_o, 32'hA5A5A5A5);
    check("col_stall", 32'(stall_o), 32'(0));
    step();
    check("col_core_landed", rf_mem[5], 32'hA5A5A5A5);
    check("col_still_idle", 32'(stall_o), 32'(0));
    ref_regs[5] = 32'hA5A5A5A5;
    core_we_ni  = 1'b1;
    dbg_finish(1'b1, 5'd5, 32'h5A5A5A5A, 0);
    check("col_final_x5", rf_mem[5], 32'h5A5A5A5A);

    // Held request
    dbg_txn(1'b1, 5'd12, 32'hC0FFEE12, 10);

    // Mixed random traffic
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1)
        dbg_txn(1'($urandom_range(0, 1)), SW'($urandom), $urandom, int'($urandom_range(0, 3)));
      else
        core_wr(1'b0, SW'($urandom), $urandom, SW'($urandom));
    end
    idle_inputs();
    check_all_regs("mixed");
    dbg_txn(1'b0, 5'd7, 32'h0, 0);

    // Reset in the DBG_WR cycle
    core_wr(1'b0, 5'd9, 32'hCAFEF00D, 5'd0);
    check("x9_preset", rf_mem[9], 32'hCAFEF00D);
    core_we_ni  = 1'b1;
    dbg_req_i   = 1'b1;
    dbg_wr_i    = 1'b1;
    dbg_addr_i  = 5'd9;
    dbg_wdata_i = 32'h11111111;
    step();
    reset_i = 1'b1;
    settle();
    check("mid_we_n", 32'(rf_we_no), 32'(0));
    check("mid_dst", 32'(rf_dst_o), 32'(0));
    check("mid_ack", 32'(dbg_ack_o), 32'(0));
    check("mid_ready", 32'(ready_o), 32'(0));
    step();
    check("mid_ack_after", 32'(dbg_ack_o), 32'(0));
    check("mid_rdata", dbg_rdata_o, 32'(0));
    dbg_req_i = 1'b0;
    reset_i   = 1'b0;
    settle();
    wait_clear("reclr");
    exp_rdata = '0;
    check("x9_cleared", rf_mem[9], 32'(0));
    check_all_regs("after_reclr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Sequencer and arbiter in front of the 32x32 register file in the multi-cycle RV32I core. After reset it zero-fills every register. It then shares the file's single write port, and its srcB read select, between the core writeback path and a debug access port. Writes to x0 are suppressed so x0 always reads zero. The block owns the file's write-enable, destination, data and srcB-select inputs; the core's srcA path bypasses it.

## Interface
- DATA_WIDTH, 32, register width
- WORDS, 32, number of registers
- SELECT_SIZE, 5, register select width (2^SELECT_SIZE = WORDS)

- clk_i  in  1  clock; all state changes on rising edge
- reset_i  in  1  synchronous, active-high reset
- core_we_ni  in  1  core writeback request, active low
- core_dst_i  in  SELECT_SIZE  core destination register
- core_data_i  in  DATA_WIDTH  core writeback data
- core_srcB_i  in  SELECT_SIZE  core srcB select
- stall_o  out  1  core must hold (no writeback, no srcB use) while high
- ready_o  out  1  clear sequence finished
- dbg_req_i  in  1  debug request, level, 4-phase
- dbg_wr_i  in  1  1 = write, 0 = read; stable while dbg_req_i high
- dbg_addr_i  in  SELECT_SIZE  debug register address
- dbg_wdata_i  in  DATA_WIDTH  debug write data
- dbg_ack_o  out  1  debug transaction done; held until dbg_req_i drops
- dbg_rdata_o  out  DATA_WIDTH  registered debug read data
- rf_we_no  out  1  to register file write enable, active low
- rf_dst_o  out  SELECT_SIZE  to register file destination select
- rf_data_o  out  DATA_WIDTH  to register file data input
- rf_srcB_o  out  SELECT_SIZE  to register file srcB select
- rf_srcB_data_i  in  DATA_WIDTH  register file srcB output

## Operation
- States: CLEAR, IDLE, DBG_WR, DBG_RD, DBG_ACK. The clear counter `clr_cnt` is SELECT_SIZE bits wide.
- **CLEAR**
  - Drives rf_we_no=0, rf_dst_o=clr_cnt, rf_data_o=0.
  - clr_cnt increments each cycle.
  - After the write with clr_cnt==WORDS-1, goes to IDLE and clr_cnt returns to 0.
  - Core and debug requests are ignored.
  - This is the only path that writes x0.
- **IDLE**
  - Core writeback passes through combinationally: rf_we_no = core_we_ni OR (core_dst_i==0); rf_dst_o=core_dst_i; rf_data_o=core_data_i; rf_srcB_o=core_srcB_i.
  - If dbg_req_i=1 and core_we_ni=1, the request is accepted. dbg_addr_i and dbg_wdata_i are latched, and the next state is DBG_WR if dbg_wr_i=1, else DBG_RD.
  - If dbg_req_i=1 and core_we_ni=0, the core wins that cycle. The debug request stays pending and is re-sampled on the next cycle.
- **DBG_WR**
  - rf_we_no=0 unless the latched address is 0 (write dropped, ack still given).
  - rf_dst_o and rf_data_o are the latched values.
  - Next state: DBG_ACK.
- **DBG_RD**
  - rf_we_no=1; rf_srcB_o = latched address.
  - dbg_rdata_o <= rf_srcB_data_i at the end of the cycle.
  - Next state: DBG_ACK.
- **DBG_ACK**
  - dbg_ack_o=1 and rf_we_no=1.
  - Stays in DBG_ACK while dbg_req_i=1; goes to IDLE on the first cycle dbg_req_i=0.
- stall_o is asserted in every state except IDLE.
- ready_o=1 in every state except CLEAR.
- dbg_rdata_o changes only on a DBG_RD cycle or on reset.
- Outside DBG_RD, rf_srcB_o=core_srcB_i.
- Outside CLEAR, DBG_WR and IDLE, rf_dst_o and rf_data_o are don't-care, with rf_we_no=1.

## Timing
- **Reset**
  - Synchronous and takes priority over everything.
  - On the edge where reset_i=1: state=CLEAR, clr_cnt=0, dbg_rdata_o=0.
  - While reset_i is held, outputs are: stall_o=1, ready_o=0, dbg_ack_o=0, rf_we_no=0, rf_dst_o=0, rf_data_o=0.
- **Clear duration**
  - x0 is written during the cycles reset is high. The counter starts advancing on the first edge with reset_i=0.
  - The last clear write (x31) occurs WORDS-1 cycles after reset release.
  - ready_o=1 and stall_o=0 from the cycle after that write.
- **Reset mid-operation** (any state, including DBG_WR or DBG_ACK)
  - Abandons the debug transaction: no ack, dbg_ack_o=0 next cycle.
  - Restarts the full clear from x0.
- **Debug latency**
  - Request sampled high in IDLE at cycle T.
  - Register write or read sample happens at the end of T+1.
  - dbg_ack_o=1 from T+2.
  - After dbg_req_i falls at cycle U, dbg_ack_o=0 and stall_o=0 at U+1.
- **Debug request stability**
  - dbg_addr_i and dbg_wdata_i are captured at acceptance; later changes have no effect.
  - The requester must drop dbg_req_i before starting a new transaction.
- **Core behaviour**
  - Core writes are never delayed, only preempted by stall_o.
  - The core must not assert core_we_ni=0 while stall_o=1; such writes are ignored.

## Test plan
- **Reset clear:** pre-load all registers with 0xFFFFFFFF, pulse reset_i for 1 cycle -> 32 consecutive writes of 0 to x0..x31. ready_o rises exactly 32 cycles after reset release, and every register reads 0.
- **x0 protection:**
  - Core write core_dst_i=0, data 0xDEADBEEF -> rf_we_no stays 1.
  - Debug write to x0 -> ack still arrives at T+2, and x0 reads 0.
- **Debug write/read:** write 0x12345678 to x7, then read x7 -> ack at T+2 for each, dbg_rdata_o=0x12345678, stall_o high from T+1 until the cycle after dbg_req_i drops.
- **Arbitration collision:** dbg_req_i=1 and core write x5=0xA5A5A5A5 in the same IDLE cycle -> core write lands that cycle. Debug is accepted the next cycle, its write to x5=0x5A5A5A5A lands after, and x5 finally reads 0x5A5A5A5A.
- **Held request:** keep dbg_req_i high for 10 cycles after ack -> dbg_ack_o and stall_o stay 1 for all 10 cycles, with no second write.
- **Reset mid-transaction:** assert reset_i in the DBG_WR cycle -> dbg_ack_o never rises, state restarts CLEAR at x0, and the target register ends at 0.
